keccak_padder_multi: RTL and testbench
======================================

KECCAK_PADDER_MULTI -- requirements
Module: keccak_padder_multi

Interface
REQ-001 SHALL have parameter IN_W, 64, input word width in bits, legal values 32 or 64.
REQ-002 SHALL have parameter BN_W, log2(IN_W/8), width of byte_num.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in  input  IN_W  message word, first message byte in bits [IN_W-1:IN_W-8].
REQ-006 SHALL have port in_ready  input  1  in is valid this cycle.
REQ-007 SHALL have port is_last  input  1  in is the final word of the message.
REQ-008 SHALL have port byte_num  input  BN_W  valid bytes in the final word, counted from the MSB, range 0..IN_W/8-1; ignored when is_last=0.
REQ-009 SHALL have port mode  input  3  0 SHA3-224 (rate 144 B), 1 SHA3-256 (136 B), 2 SHA3-384 (104 B), 3 SHA3-512 (72 B), 4 SHAKE128 (168 B), 5 SHAKE256 (136 B); codes 6-7 are treated as 3.
REQ-010 SHALL have port f_ack  input  1  permutation core has absorbed out; one-cycle pulse.
REQ-011 SHALL have port buffer_full  output  1  no word is accepted this cycle.
REQ-012 SHALL have port out  output  1344  padded rate block, byte 0 in bits [1343:1336], bits beyond the rate held at 0.
REQ-013 SHALL have port out_ready  output  1  out holds a complete block.
REQ-014 SHALL have port out_last  output  1  the block in out is the final block of the message.

Function
REQ-015 SHALL implement states IDLE, FILL and FULL, with a word counter cnt ranging 0..W-1, where W = rate_bytes*8/IN_W.
REQ-016 SHALL accept a word when in_ready=1 and buffer_full=0, and in no other case.
REQ-017 SHALL drive buffer_full=1 in FULL and buffer_full=0 in IDLE and FILL.
REQ-018 SHALL latch mode on the first word accepted in IDLE; mode changes during FILL or FULL are ignored until the next IDLE.
REQ-019 SHALL, on accepting a non-last word, write it to word slot cnt and increment cnt; if cnt was W-1, go to FULL with out_last=0, otherwise go to or stay in FILL.
REQ-020 SHALL, on accepting a word with is_last=1, perform all of the following:
- keep the top byte_num bytes;
- place suffix D (0x06 for SHA3 modes, 0x1F for SHAKE modes) in the byte immediately after them;
- zero all later bytes of the block;
- OR 0x80 into byte rate_bytes-1;
- go to FULL with out_last=1.
REQ-021 SHALL, when D and 0x80 fall in the same byte, produce 0x86 (SHA3) or 0x9F (SHAKE) in that byte.
REQ-022 SHALL complete padding within the current block in all cases; because byte_num < IN_W/8 there is always a free byte, so no extra padding-only block is ever produced.
REQ-023 SHALL assert out_ready on the clock edge that accepts the completing word, i.e. out_ready is visible in the following cycle, and hold out, out_ready and out_last stable while in FULL.
REQ-024 SHALL, on f_ack in FULL:
- clear out to 0, clear cnt, drop out_ready and out_last;
- go to IDLE if out_last=1, otherwise to FILL;
- accept words from the next cycle onward.
REQ-025 SHALL ignore f_ack outside FULL.
REQ-026 SHALL NOT accept a word presented with in_ready=1 in the same cycle as f_ack, because buffer_full is still 1 in that cycle.
REQ-027 SHALL accept a new message directly after IDLE is re-entered, with no reset required between messages.

Reset
REQ-028 SHALL, on reset_n=0 and regardless of clock or state, force state=IDLE, cnt=0, out=0, out_ready=0, out_last=0, buffer_full=0 and latched mode=3.
REQ-029 SHALL discard any partially filled block when reset is applied mid-message; the first word after reset_n rises is treated as a new message.

Verification
REQ-030 SHALL cover: IN_W=32, mode=3, in=0x61626300, byte_num=3, is_last=1 -> next cycle out_ready=1, out_last=1, out[1343:1312]=0x61626306, byte 71=0x80, bytes 4-70 and all bits beyond byte 71 =0.
REQ-031 SHALL cover: IN_W=64, mode=4, empty message (in=0x1234, byte_num=0, is_last=1) -> byte 0=0x1F, byte 167=0x80, all other bytes 0; a second word held during FULL is not accepted.
REQ-032 SHALL cover: IN_W=64, mode=3, 9 non-last words -> out_ready=1, out_last=0, buffer_full=1; a 10th word held 3 cycles is not taken; f_ack accepts it the cycle after the pulse, cnt=1.
REQ-033 SHALL cover: IN_W=32, mode=0, 35 full words then the 36th word with byte_num=3, is_last=1 -> byte 143=0x86.
REQ-034 SHALL cover: reset_n pulsed low asynchronously (between edges) after 5 accepted words -> outputs 0 immediately; a following 3-byte message in mode 1 pads at bytes 3 and 135.
REQ-035 SHALL cover: two back-to-back messages (mode 5, then mode 2) with f_ack in between -> second block uses rate 104 B, 0x06 suffix.

Source files
------------

// File: rtl/keccak_padder_multi.sv
// keccak_padder_multi
//   Collects message words into one Keccak rate block. When a block is
//   complete it applies SHA3/SHAKE padding to the final block and hands the
//   block to the permutation core.
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   in           message word; first message byte in in[IN_W-1:IN_W-8]
//   in_ready     in is valid this cycle
//   is_last      in is the final word of the message
//   byte_num     valid bytes in the final word, counted from the MSB
//   mode         0..5 = SHA3-224/256/384/512, SHAKE128/256; 6,7 act as 3
//   f_ack        one-cycle pulse: the core has absorbed out
//   buffer_full  no word is accepted this cycle
//   out          padded rate block; byte 0 in out[1343:1336]
//   out_ready    out holds a complete block
//   out_last     the block in out is the final block of the message
module keccak_padder_multi #(
  parameter int IN_W = 64,
  parameter int BN_W = $clog2(IN_W / 8)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [IN_W-1:0]   in,
  input  logic              in_ready,
  input  logic              is_last,
  input  logic [BN_W-1:0]   byte_num,
  input  logic [2:0]        mode,
  input  logic              f_ack,
  output logic              buffer_full,
  output logic [1343:0]     out,
  output logic              out_ready,
  output logic              out_last
);

  localparam int OUT_W = 1344;
  localparam int NB    = IN_W / 8;
  // Largest block is SHAKE128 with 32-bit words: 42 slots.
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    FULL
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic               out_ready_q, out_ready_d;
  logic               out_last_q, out_last_d;
  logic               buffer_full_q, buffer_full_d;
  logic [2:0]         mode_q, mode_d;

  logic [2:0]         cur_mode;
  logic               accept;
  int                 rate;
  int                 words;
  int                 word_base;
  int                 pad_base;

  // Codes 6 and 7 are folded onto SHA3-512.
  function automatic logic [2:0] norm_mode(input logic [2:0] m);
    return (m > 3'd5) ? 3'd3 : m;
  endfunction

  function automatic int rate_bytes(input logic [2:0] m);
    case (m)
      3'd0:    return 144;
      3'd1:    return 136;
      3'd2:    return 104;
      3'd3:    return 72;
      3'd4:    return 168;
      3'd5:    return 136;
      default: return 72;
    endcase
  endfunction

  function automatic logic [7:0] suffix(input logic [2:0] m);
    return ((m == 3'd4) || (m == 3'd5)) ? 8'h1F : 8'h06;
  endfunction

  // Keeps the leading bn bytes, puts the domain suffix right after them and
  // clears the remainder of the word.
  function automatic logic [IN_W-1:0] pad_word(input logic [IN_W-1:0] w,
                                               input logic [BN_W-1:0] bn,
                                               input logic [7:0]      d);
    logic [IN_W-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++) begin
      if (i < int'(bn)) begin
        r[IN_W-1-8*i -: 8] = w[IN_W-1-8*i -: 8];
      end else if (i == int'(bn)) begin
        r[IN_W-1-8*i -: 8] = d;
      end
    end
    return r;
  endfunction

  // Mode comes straight from the port only while idle; afterwards the
  // latched copy governs the whole message.
  always_comb begin
    cur_mode  = (state_q == IDLE) ? norm_mode(mode) : mode_q;
    rate      = rate_bytes(cur_mode);
    words     = (rate * 8) / IN_W;
    accept    = in_ready && (state_q != FULL);
    word_base = OUT_W - 1 - int'(cnt_q) * IN_W;
    pad_base  = OUT_W - 1 - 8 * (rate - 1);
  end

  // Next-state logic. Slots are written strictly in order into a block that
  // starts out all-zero (after reset or f_ack), so every byte beyond the
  // padded last word, including bytes beyond the rate, is already zero.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_ready_d = out_ready_q;
    out_last_d  = out_last_q;
    mode_d      = mode_q;

    case (state_q)
      IDLE, FILL: begin
        if (accept) begin
          if (state_q == IDLE) begin
            mode_d = cur_mode;
          end
          if (is_last) begin
            out_d[word_base -: IN_W] = pad_word(in, byte_num, suffix(cur_mode));
            // When the suffix landed in the final rate byte this OR yields
            // 0x86 / 0x9F.
            out_d[pad_base -: 8] = out_d[pad_base -: 8] | 8'h80;
            state_d     = FULL;
            out_ready_d = 1'b1;
            out_last_d  = 1'b1;
            cnt_d       = '0;
          end else begin
            out_d[word_base -: IN_W] = in;
            if (int'(cnt_q) == words - 1) begin
              state_d     = FULL;
              out_ready_d = 1'b1;
              out_last_d  = 1'b0;
              cnt_d       = '0;
            end else begin
              state_d = FILL;
              cnt_d   = cnt_q + 1'b1;
            end
          end
        end
      end
      FULL: begin
        if (f_ack) begin
          out_d       = '0;
          cnt_d       = '0;
          out_ready_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = out_last_q ? IDLE : FILL;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    buffer_full_d = (state_d == FULL);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      out_q         <= '0;
      out_ready_q   <= 1'b0;
      out_last_q    <= 1'b0;
      buffer_full_q <= 1'b0;
      mode_q        <= 3'd3;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      out_q         <= out_d;
      out_ready_q   <= out_ready_d;
      out_last_q    <= out_last_d;
      buffer_full_q <= buffer_full_d;
      mode_q        <= mode_d;
    end
  end

  assign buffer_full = buffer_full_q;
  assign out         = out_q;
  assign out_ready   = out_ready_q;
  assign out_last    = out_last_q;

endmodule

// File: tb/tb_keccak_padder_multi.sv
// Testbench for keccak_padder_multi: one 64-bit and one 32-bit instance.
// Expected blocks come from a byte-level pad10*1 model and are queued when a
// message is issued; per-instance monitors compare each presented block.
module tb_keccak_padder_multi;

  typedef struct packed {
    logic [1343:0] data;
    logic          last;
  } blk_t;

  logic          clk;
  logic          reset_n;

  logic [63:0]   in64;
  logic          in_ready64, is_last64, f_ack64;
  logic [2:0]    bn64, mode64;
  logic          buffer_full64, out_ready64, out_last64;
  logic [1343:0] out64;

  logic [31:0]   in32;
  logic          in_ready32, is_last32, f_ack32;
  logic [1:0]    bn32;
  logic [2:0]    mode32;
  logic          buffer_full32, out_ready32, out_last32;
  logic [1343:0] out32;

  int   n_cmp;
  int   n_fail;
  blk_t exp64[$];
  blk_t exp32[$];
  bit   rand_ack;
  int   ack_delay;

  keccak_padder_multi #(.IN_W(64)) dut64 (
    .clk(clk), .reset_n(reset_n), .in(in64), .in_ready(in_ready64),
    .is_last(is_last64), .byte_num(bn64), .mode(mode64), .f_ack(f_ack64),
    .buffer_full(buffer_full64), .out(out64), .out_ready(out_ready64),
    .out_last(out_last64)
  );

  keccak_padder_multi #(.IN_W(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .in(in32), .in_ready(in_ready32),
    .is_last(is_last32), .byte_num(bn32), .mode(mode32), .f_ack(f_ack32),
    .buffer_full(buffer_full32), .out(out32), .out_ready(out_ready32),
    .out_last(out_last32)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cmp_block(input string nm, input logic [1343:0] act, input logic [1343:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      for (int k = 0; k < 168; k++) begin
        if (act[1343-8*k -: 8] !== exp[1343-8*k -: 8]) begin
          $display("FAIL %s: byte %0d got %02h expected %02h", nm, k,
                   act[1343-8*k -: 8], exp[1343-8*k -: 8]);
          break;
        end
      end
    end
  endtask

  function automatic int model_rate(input logic [2:0] m);
    int r[8] = '{144, 136, 104, 72, 168, 136, 72, 72};
    return r[m];
  endfunction

  function automatic logic bf(input int w);
    return (w == 64) ? buffer_full64 : buffer_full32;
  endfunction

  function automatic int cnt_of(input int w);
    return (w == 64) ? int'(dut64.cnt_q) : int'(dut32.cnt_q);
  endfunction

  // Byte-level pad10*1: append the domain byte, zero-fill to a rate
  // multiple, set the top bit of the final byte, then cut into blocks.
  task automatic push_expected(input int w, input logic [2:0] md, input logic [7:0] msg[$]);
    logic [7:0]    p[$];
    int            r;
    int            nblk;
    blk_t          b;
    r = model_rate(md);
    p = msg;
    p.push_back((md == 3'd4 || md == 3'd5) ? 8'h1F : 8'h06);
    while ((p.size() % r) != 0) p.push_back(8'h00);
    p[p.size()-1] = p[p.size()-1] | 8'h80;
    nblk = p.size() / r;
    for (int bk = 0; bk < nblk; bk++) begin
      b.data = '0;
      for (int k = 0; k < r; k++) b.data[1343-8*k -: 8] = p[bk*r+k];
      b.last = (bk == nblk - 1);
      if (w == 64) exp64.push_back(b);
      else         exp32.push_back(b);
    end
  endtask

  // Presents one word and holds it until taken; hold_n cycles of refusal are
  // required first.
  task automatic send_word(input int w, input logic [63:0] data, input bit last,
                           input int bn, input logic [2:0] md, input int hold_n);
    int budget;
    @(negedge clk);
    if (w == 64) begin
      in64 = data; is_last64 = last; bn64 = 3'(bn); mode64 = md; in_ready64 = 1'b1;
    end else begin
      in32 = data[63:32]; is_last32 = last; bn32 = 2'(bn); mode32 = md; in_ready32 = 1'b1;
    end
    for (int k = 0; k < hold_n; k++) begin
      check("held_word_refused", 64'(bf(w)), 64'd1);
      @(negedge clk);
    end
    budget = 0;
    while (bf(w)) begin
      budget++;
      if (budget > 500) begin
        n_cmp++; n_fail++;
        $display("FAIL accept_timeout: word never accepted, expected within 500 cycles");
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic send_msg(input int w, input logic [2:0] md, input logic [7:0] msg[$],
                          input int hold_idx, input int hold_n);
    int          nb, nwords, idx, wpb;
    logic [63:0] data;
    bit          last;
    nb     = w / 8;
    nwords = msg.size() / nb + 1;
    wpb    = model_rate((md > 3'd5) ? 3'd3 : md) * 8 / w;
    push_expected(w, (md > 3'd5) ? 3'd3 : md, msg);
    for (int i = 0; i < nwords; i++) begin
      data = {$urandom, $urandom};
      for (int b = 0; b < nb; b++) begin
        idx = i * nb + b;
        if (idx < msg.size()) data[63-8*b -: 8] = msg[idx];
      end
      last = (i == nwords - 1);
      send_word(w, data, last, last ? (msg.size() % nb) : int'($urandom_range(0, nb-1)),
                (i == 0) ? md : 3'($urandom), (i == hold_idx) ? hold_n : 0);
      if (i == hold_idx && hold_n > 0 && !last && ((i % wpb) + 1) < wpb) begin
        @(posedge clk);
        #1;
        check("cnt_after_held_word", 64'(cnt_of(w)), 64'((i % wpb) + 1));
      end
    end
    @(negedge clk);
    if (w == 64) in_ready64 = 1'b0;
    else         in_ready32 = 1'b0;
  endtask

  task automatic rand_msg(input int len, output logic [7:0] m[$]);
    m = {};
    for (int i = 0; i < len; i++) m.push_back(8'($urandom));
  endtask

  // Permutation-core stand-ins: acknowledge each block after a delay.
  initial begin
    int d;
    f_ack64 = 1'b0;
    forever begin
      @(negedge clk);
      if (out_ready64) begin
        d = rand_ack ? int'($urandom_range(1, 6)) : ack_delay;
        repeat (d - 1) @(negedge clk);
        f_ack64 = 1'b1;
        @(negedge clk);
        f_ack64 = 1'b0;
      end
    end
  end

  initial begin
    int d;
    f_ack32 = 1'b0;
    forever begin
      @(negedge clk);
      if (out_ready32) begin
        d = rand_ack ? int'($urandom_range(1, 6)) : ack_delay;
        repeat (d - 1) @(negedge clk);
        f_ack32 = 1'b1;
        @(negedge clk);
        f_ack32 = 1'b0;
      end
    end
  end

  // Monitors: pop on each newly presented block, then require it to stay
  // unchanged for as long as out_ready holds.
  initial begin
    bit   prev;
    blk_t cur;
    prev = 1'b0;
    cur  = '0;
    forever begin
      @(negedge clk);
      if (out_ready64) begin
        if (!prev) begin
          if (exp64.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_block64: out_ready=1 expected no block");
          end else begin
            cur = exp64.pop_front();
          end
        end
        cmp_block("block64", out64, cur.data);
        check("out_last64", 64'(out_last64), 64'(cur.last));
      end
      prev = out_ready64;
    end
  end

  initial begin
    bit   prev;
    blk_t cur;
    prev = 1'b0;
    cur  = '0;
    forever begin
      @(negedge clk);
      if (out_ready32) begin
        if (!prev) begin
          if (exp32.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_block32: out_ready=1 expected no block");
          end else begin
            cur = exp32.pop_front();
          end
        end
        cmp_block("block32", out32, cur.data);
        check("out_last32", 64'(out_last32), 64'(cur.last));
      end
      prev = out_ready32;
    end
  end

  initial begin
    logic [7:0] m[$];
    int         budget;
    n_cmp = 0; n_fail = 0;
    rand_ack = 1'b0; ack_delay = 5;
    reset_n = 1'b0;
    in64 = '0; in_ready64 = 1'b0; is_last64 = 1'b0; bn64 = '0; mode64 = 3'd3;
    in32 = '0; in_ready32 = 1'b0; is_last32 = 1'b0; bn32 = '0; mode32 = 3'd3;

    repeat (3) @(negedge clk);
    check("rst_buffer_full64", 64'(buffer_full64), 64'd0);
    check("rst_out_ready64",   64'(out_ready64),   64'd0);
    check("rst_out_last64",    64'(out_last64),    64'd0);
    check("rst_out_zero64",    64'(out64 == '0),   64'd1);
    check("rst_out_ready32",   64'(out_ready32),   64'd0);
    check("rst_out_zero32",    64'(out32 == '0),   64'd1);
    reset_n = 1'b1;

    // "abc" in SHA3-512 on the 32-bit instance.
    m = {8'h61, 8'h62, 8'h63};
    send_msg(32, 3'd3, m, -1, 0);
    check("abc_out_ready", 64'(out_ready32), 64'd1);
    check("abc_out_last",  64'(out_last32),  64'd1);
    check("abc_word0",     64'(out32[1343:1312]), 64'h61626306);
    check("abc_byte71",    64'(out32[1343-71*8 -: 8]), 64'h80);

    // 143 bytes in SHA3-224: suffix and final bit share byte 143.
    rand_msg(143, m);
    send_msg(32, 3'd0, m, -1, 0);
    check("merged_byte143", 64'(out32[1343-143*8 -: 8]), 64'h86);

    // Empty SHAKE128 message, then a word held against FULL.
    m = {};
    send_msg(64, 3'd4, m, -1, 0);
    check("empty_byte0",   64'(out64[1343:1336]), 64'h1F);
    check("empty_byte167", 64'(out64[1343-167*8 -: 8]), 64'h80);
    rand_msg(20, m);
    send_msg(64, 3'd1, m, 0, 2);

    // Nine full words fill a SHA3-512 block; the tenth waits for f_ack.
    rand_msg(83, m);
    send_msg(64, 3'd3, m, 9, 3);

    // Reset between clock edges in the middle of a message.
    repeat (12) @(negedge clk);
    for (int i = 0; i < 5; i++) send_word(64, {$urandom, $urandom}, 1'b0, 0, 3'd3, 0);
    @(negedge clk);
    in_ready64 = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_out_zero",  64'(out64 == '0), 64'd1);
    check("async_rst_out_ready", 64'(out_ready64), 64'd0);
    check("async_rst_bfull",     64'(buffer_full64), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    rand_msg(3, m);
    send_msg(64, 3'd1, m, -1, 0);
    check("post_rst_byte3",   64'(out64[1343-3*8 -: 8]), 64'h06);
    check("post_rst_byte135", 64'(out64[1343-135*8 -: 8]), 64'h80);

    // Back-to-back SHAKE256 then SHA3-384.
    rand_msg(50, m);
    send_msg(64, 3'd5, m, -1, 0);
    rand_msg(20, m);
    send_msg(64, 3'd2, m, -1, 0);
    check("b2b_byte20",  64'(out64[1343-20*8 -: 8]), 64'h06);
    check("b2b_byte103", 64'(out64[1343-103*8 -: 8]), 64'h80);
    check("b2b_tail",    64'(out64[511:0] == '0), 64'd1);

    // Randomized messages on both instances concurrently.
    rand_ack = 1'b1;
    fork
      begin
        logic [7:0] q[$];
        for (int n = 0; n < 12; n++) begin
          rand_msg(int'($urandom_range(0, 400)), q);
          send_msg(64, 3'($urandom), q, -1, 0);
        end
      end
      begin
        logic [7:0] q[$];
        for (int n = 0; n < 12; n++) begin
          rand_msg(int'($urandom_range(0, 300)), q);
          send_msg(32, 3'($urandom), q, -1, 0);
        end
      end
    join

    budget = 0;
    while ((exp64.size() != 0 || exp32.size() != 0) && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    check("pending_blocks", 64'(exp64.size() + exp32.size()), 64'd0);
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
